// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Holds the fetch FSM state type, the PC width, the bubble instruction,
// and a small helper for sequential PC arithmetic.
package fetch_unit_pkg;

  localparam int PC_WIDTH = 32;

  // addi x0,x0,0 -- the canonical RISC-V no-op used to fill bubble slots
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  // Sequential PC; wraps modulo 2^32 by construction of the width
  function automatic logic [PC_WIDTH-1:0] pc_plus4(input logic [PC_WIDTH-1:0] pc);
    return pc + PC_WIDTH'(4);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus.
//   proc2Imem_req   : one-cycle request pulse from the fetch unit
//   proc2Imem_addr  : request address, stable until the response
//   Imem2proc_data  : instruction word returned by memory
//   Imem2proc_valid : response strobe
// master = fetch unit side, slave = memory side.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic                proc2Imem_req;
  logic [PC_WIDTH-1:0] proc2Imem_addr;
  logic [31:0]         Imem2proc_data;
  logic                Imem2proc_valid;

  modport master (
    output proc2Imem_req,
    output proc2Imem_addr,
    input  Imem2proc_data,
    input  Imem2proc_valid
  );

  modport slave (
    input  proc2Imem_req,
    input  proc2Imem_addr,
    output Imem2proc_data,
    output Imem2proc_valid
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs a single-outstanding
// request handshake to instruction memory, buffers a returned instruction
// while decode stalls, and applies EX redirects by squashing wrong-path
// fetches.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   id_stall          : decode stall, IF/ID must hold
//   ex_take_branch    : redirect request from EX
//   ex_target_pc      : redirect target (low two bits forced to zero)
//   imem              : instruction-memory bus (master side)
//   if_id_IR/PC/NPC   : IF/ID register contents to decode
//   if_id_valid_inst  : IF/ID holds a real instruction
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = fetch_unit_pkg::NOP_INST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_stall,
  input  logic                ex_take_branch,
  input  logic [PC_WIDTH-1:0] ex_target_pc,
  fetch_unit_if.master        imem,
  output logic [31:0]         if_id_IR,
  output logic [PC_WIDTH-1:0] if_id_PC,
  output logic [PC_WIDTH-1:0] if_id_NPC,
  output logic                if_id_valid_inst
);

  fetch_state_t        state, state_n;
  logic [PC_WIDTH-1:0] pc, pc_n;
  logic                drop, drop_n;
  logic [PC_WIDTH-1:0] addr_q, addr_n;
  logic [31:0]         hold_ir, hold_ir_n;
  logic [PC_WIDTH-1:0] hold_pc, hold_pc_n;
  logic [31:0]         ir_n;
  logic [PC_WIDTH-1:0] id_pc_n, id_npc_n;
  logic                valid_n;
  logic [PC_WIDTH-1:0] target_pc;

  assign target_pc = ex_target_pc & ~PC_WIDTH'(3);

  // The request is a pure function of state, so it can never be raised in
  // WAIT or HOLD; reset gates it so nothing is issued while rst is high.
  assign imem.proc2Imem_req  = (state == FETCH) && !rst;
  assign imem.proc2Imem_addr = addr_q;

  // State register. When reset lands while a request is outstanding, the
  // drop flag is armed so the stale response is discarded; if that response
  // shows up during reset itself it is consumed there and drop stays clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= FETCH;
      pc               <= RESET_PC;
      drop             <= ((state == WAIT) || drop) && !imem.Imem2proc_valid;
      addr_q           <= RESET_PC;
      hold_ir          <= '0;
      hold_pc          <= '0;
      if_id_IR         <= NOP_INST;
      if_id_PC         <= '0;
      if_id_NPC        <= '0;
      if_id_valid_inst <= 1'b0;
    end else begin
      state            <= state_n;
      pc               <= pc_n;
      drop             <= drop_n;
      addr_q           <= addr_n;
      hold_ir          <= hold_ir_n;
      hold_pc          <= hold_pc_n;
      if_id_IR         <= ir_n;
      if_id_PC         <= id_pc_n;
      if_id_NPC        <= id_npc_n;
      if_id_valid_inst <= valid_n;
    end
  end

  // Next-state logic. Normal FSM behaviour is resolved first, then a
  // redirect overrides whatever it decided, since a taken branch beats
  // stall, response and state alike.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    drop_n    = drop;
    hold_ir_n = hold_ir;
    hold_pc_n = hold_pc;
    ir_n      = if_id_IR;
    id_pc_n   = if_id_PC;
    id_npc_n  = if_id_NPC;
    valid_n   = if_id_valid_inst;

    // Default when decode is free: a bubble, with PC/NPC left as they were
    if (!id_stall) begin
      ir_n    = NOP_INST;
      valid_n = 1'b0;
    end

    case (state)
      FETCH: begin
        state_n = WAIT;
        // A response seen in FETCH can only be the leftover from a request
        // aborted by reset, so it retires the pending drop.
        if (imem.Imem2proc_valid && drop) drop_n = 1'b0;
      end
      WAIT: begin
        if (imem.Imem2proc_valid) begin
          if (drop) begin
            drop_n  = 1'b0;
            state_n = FETCH;
          end else if (!id_stall) begin
            ir_n     = imem.Imem2proc_data;
            id_pc_n  = pc;
            id_npc_n = pc_plus4(pc);
            valid_n  = 1'b1;
            pc_n     = pc_plus4(pc);
            state_n  = FETCH;
          end else begin
            hold_ir_n = imem.Imem2proc_data;
            hold_pc_n = pc;
            state_n   = HOLD;
          end
        end
      end
      HOLD: begin
        if (!id_stall) begin
          ir_n     = hold_ir;
          id_pc_n  = hold_pc;
          id_npc_n = pc_plus4(hold_pc);
          valid_n  = 1'b1;
          pc_n     = pc_plus4(pc);
          state_n  = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase

    if (ex_take_branch) begin
      pc_n      = target_pc;
      ir_n      = NOP_INST;
      valid_n   = 1'b0;
      hold_ir_n = '0;
      hold_pc_n = '0;
      case (state)
        // The request issued this cycle is still outstanding, so wait for
        // it and throw its response away rather than issuing a second one.
        FETCH: begin
          state_n = WAIT;
          drop_n  = 1'b1;
        end
        WAIT: begin
          if (imem.Imem2proc_valid) begin
            state_n = FETCH;
            drop_n  = 1'b0;
          end else begin
            state_n = WAIT;
            drop_n  = 1'b1;
          end
        end
        default: begin
          state_n = FETCH;
          drop_n  = 1'b0;
        end
      endcase
    end

    // The address register tracks pc only when the next cycle issues a
    // request, so it stays frozen across WAIT even if a redirect moves pc.
    addr_n = (state_n == FETCH) ? pc_n : addr_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. A table of per-cycle vectors drives
// stall, redirect and the memory response by hand and lists the expected
// request (mid-cycle) and IF/ID contents (after the edge).
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        vld;
    logic [31:0] data;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_ir;
    logic [31:0] exp_pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_stall;
  logic        ex_take_branch;
  logic [31:0] ex_target_pc;
  logic [31:0] if_id_IR;
  logic [31:0] if_id_PC;
  logic [31:0] if_id_NPC;
  logic        if_id_valid_inst;

  int tests_run    = 0;
  int tests_failed = 0;
  vec_t vecs[$];

  fetch_unit_if imem_bus();

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_stall         (id_stall),
    .ex_take_branch   (ex_take_branch),
    .ex_target_pc     (ex_target_pc),
    .imem             (imem_bus),
    .if_id_IR         (if_id_IR),
    .if_id_PC         (if_id_PC),
    .if_id_NPC        (if_id_NPC),
    .if_id_valid_inst (if_id_valid_inst)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic r, input logic s, input logic b, input logic [31:0] t,
                        input logic v, input logic [31:0] d, input logic eq,
                        input logic [31:0] ea, input logic ev, input logic [31:0] ei,
                        input logic [31:0] ep);
    vec_t x;
    x.rst = r; x.stall = s; x.br = b; x.tgt = t; x.vld = v; x.data = d;
    x.exp_req = eq; x.exp_addr = ea; x.exp_valid = ev; x.exp_ir = ei; x.exp_pc = ep;
    vecs.push_back(x);
  endtask

  // One clock cycle: drive after the falling edge, check the request before
  // the rising edge, then check the IF/ID register just after it.
  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    rst                      = v.rst;
    id_stall                 = v.stall;
    ex_take_branch           = v.br;
    ex_target_pc             = v.tgt;
    imem_bus.Imem2proc_valid = v.vld;
    imem_bus.Imem2proc_data  = v.data;
    #1;
    checkOutput({tag, " req"}, {31'b0, imem_bus.proc2Imem_req}, {31'b0, v.exp_req});
    checkOutput({tag, " addr"}, imem_bus.proc2Imem_addr, v.exp_addr);
    @(posedge clk);
    #1;
    checkOutput({tag, " valid"}, {31'b0, if_id_valid_inst}, {31'b0, v.exp_valid});
    checkOutput({tag, " IR"}, if_id_IR, v.exp_ir);
    checkOutput({tag, " PC"}, if_id_PC, v.exp_pc);
    if (v.exp_valid) checkOutput({tag, " NPC"}, if_id_NPC, v.exp_pc + 32'd4);
  endtask

  initial begin
    rst = 1'b1; id_stall = 1'b0; ex_take_branch = 1'b0; ex_target_pc = '0;
    imem_bus.Imem2proc_valid = 1'b0; imem_bus.Imem2proc_data = '0;

    // Free run, 1-cycle memory, data = addr ^ A5A5_0000
    addVec(0,0,0,0,0,0,                       1,32'h0,   0,NOP,0);
    addVec(0,0,0,0,1,32'hA5A5_0000,           0,32'h0,   1,32'hA5A5_0000,32'h0);
    addVec(0,0,0,0,0,0,                       1,32'h4,   0,NOP,32'h0);
    addVec(0,0,0,0,1,32'hA5A5_0004,           0,32'h4,   1,32'hA5A5_0004,32'h4);
    addVec(0,0,0,0,0,0,                       1,32'h8,   0,NOP,32'h4);
    addVec(0,0,0,0,1,32'hA5A5_0008,           0,32'h8,   1,32'hA5A5_0008,32'h8);
    // Stall 5 cycles while the response for 0xC arrives -> HOLD
    addVec(0,1,0,0,0,0,                       1,32'hC,   1,32'hA5A5_0008,32'h8);
    addVec(0,1,0,0,1,32'hA5A5_000C,           0,32'hC,   1,32'hA5A5_0008,32'h8);
    addVec(0,1,0,0,0,0,                       0,32'hC,   1,32'hA5A5_0008,32'h8);
    addVec(0,1,0,0,0,0,                       0,32'hC,   1,32'hA5A5_0008,32'h8);
    addVec(0,1,0,0,0,0,                       0,32'hC,   1,32'hA5A5_0008,32'h8);
    addVec(0,0,0,0,0,0,                       0,32'hC,   1,32'hA5A5_000C,32'hC);
    addVec(0,0,0,0,0,0,                       1,32'h10,  0,NOP,32'hC);
    // 4-cycle latency, redirect to 0x100 in the second WAIT cycle
    addVec(0,0,0,0,0,0,                       0,32'h10,  0,NOP,32'hC);
    addVec(0,0,1,32'h100,0,0,                 0,32'h10,  0,NOP,32'hC);
    addVec(0,0,0,0,0,0,                       0,32'h10,  0,NOP,32'hC);
    addVec(0,0,0,0,1,32'hA5A5_0010,           0,32'h10,  0,NOP,32'hC);
    addVec(0,0,0,0,0,0,                       1,32'h100, 0,NOP,32'hC);
    addVec(0,0,0,0,1,32'hDEAD_0100,           0,32'h100, 1,32'hDEAD_0100,32'h100);
    // Redirect (unaligned 0x203) with a same-cycle response under stall
    addVec(0,1,0,0,0,0,                       1,32'h104, 1,32'hDEAD_0100,32'h100);
    addVec(0,1,1,32'h203,1,32'h1111_0104,     0,32'h104, 0,NOP,32'h100);
    addVec(0,0,0,0,0,0,                       1,32'h200, 0,NOP,32'h100);
    addVec(0,0,0,0,1,32'h2222_0200,           0,32'h200, 1,32'h2222_0200,32'h200);
    // Redirect in the request cycle: req still goes out, its response dropped
    addVec(0,0,1,32'hFFFF_FFFC,0,0,           1,32'h204, 0,NOP,32'h200);
    addVec(0,0,0,0,1,32'h3333_0204,           0,32'h204, 0,NOP,32'h200);
    addVec(0,0,0,0,0,0,                       1,32'hFFFF_FFFC, 0,NOP,32'h200);
    addVec(0,0,0,0,1,32'h4444_FFFC,           0,32'hFFFF_FFFC, 1,32'h4444_FFFC,32'hFFFF_FFFC);
    addVec(0,0,0,0,0,0,                       1,32'h0,   0,NOP,32'hFFFF_FFFC);
    // Redirect while in HOLD discards the buffered instruction
    addVec(0,1,0,0,1,32'h5555_0000,           0,32'h0,   0,NOP,32'hFFFF_FFFC);
    addVec(0,1,1,32'h40,0,0,                  0,32'h0,   0,NOP,32'hFFFF_FFFC);
    addVec(0,0,0,0,0,0,                       1,32'h40,  0,NOP,32'hFFFF_FFFC);
    addVec(0,0,0,0,1,32'h6666_0040,           0,32'h40,  1,32'h6666_0040,32'h40);
    addVec(0,0,0,0,0,0,                       1,32'h44,  0,NOP,32'h40);

    // Power-on reset and reset-value checks
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset req", {31'b0, imem_bus.proc2Imem_req}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("reset addr", imem_bus.proc2Imem_addr, 32'h0);
    checkOutput("reset IR", if_id_IR, NOP);
    checkOutput("reset PC", if_id_PC, 32'h0);
    checkOutput("reset NPC", if_id_NPC, 32'h0);
    checkOutput("reset valid", {31'b0, if_id_valid_inst}, 32'h0);

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Reset while the request for 0x44 is outstanding; the stale response
    // lands in the first cycle after reset and must not reach IF/ID.
    applyStimulus('{1,0,0,0,0,0,             0,32'h44, 0,NOP,32'h0}, "rstwait");
    applyStimulus('{0,0,0,0,1,32'h7777_0044, 1,32'h0,  0,NOP,32'h0}, "stale");
    applyStimulus('{0,0,0,0,0,0,             0,32'h0,  0,NOP,32'h0}, "refetch");
    applyStimulus('{0,0,0,0,1,32'h8888_0000, 0,32'h0,  1,32'h8888_0000,32'h0}, "deliver");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end. It is the producer of the IF/ID interface that the decode stage consumes: if_id_IR, if_id_PC and if_id_valid_inst.
- Owns the PC register and runs a single-outstanding-request handshake to instruction memory.
- Buffers a returned instruction while decode is stalled.
- Applies branch/jump redirects from EX, squashing wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction (addi x0,x0,0) driven on if_id_IR when the slot is a bubble.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- id_stall  in  1  decode/hazard stall; the IF/ID register must hold.
- ex_take_branch  in  1  redirect request from EX (taken branch, JAL, JALR).
- ex_target_pc  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- Imem2proc_data  in  32  instruction word returned by memory.
- Imem2proc_valid  in  1  response strobe; arrives at least 1 cycle after the request, with unbounded latency.
- proc2Imem_req  out  1  one-cycle request pulse.
- proc2Imem_addr  out  32  request address; stable from the req cycle until the response.
- if_id_IR  out  32  instruction to decode.
- if_id_PC  out  32  PC of if_id_IR.
- if_id_NPC  out  32  if_id_PC + 4.
- if_id_valid_inst  out  1  if_id_IR is a real instruction.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high, on clk and rst.
- Reset values: pc=RESET_PC, state=FETCH, drop=0, proc2Imem_req=0, proc2Imem_addr=RESET_PC, if_id_IR=NOP_INST, if_id_PC=0, if_id_NPC=0, if_id_valid_inst=0, hold buffer cleared.
- Reset asserted mid-operation aborts everything. Any response arriving during or after reset, for a request issued before it, must be ignored; the drop flag is set when rst hits in WAIT.
- FSM states: FETCH, WAIT, HOLD.
- FETCH:
  - Drive proc2Imem_req=1 for exactly one cycle, with proc2Imem_addr=pc.
  - Next state is WAIT.
- WAIT, on Imem2proc_valid with drop=1:
  - Discard the data and clear drop.
  - Next state is FETCH; pc already holds the redirect target.
- WAIT, on Imem2proc_valid with drop=0 and id_stall=0:
  - Load IF/ID at the next edge: IR=data, PC=pc, NPC=pc+4, valid=1.
  - pc <= pc+4; next state is FETCH.
- WAIT, on Imem2proc_valid with drop=0 and id_stall=1:
  - Capture data and pc into the hold buffer.
  - Next state is HOLD.
- WAIT with no response: remain in WAIT.
- HOLD:
  - When id_stall=0, move the hold buffer into IF/ID (valid=1), set pc <= pc+4, and go to FETCH.
  - Otherwise remain in HOLD.
- IF/ID register rules:
  - id_stall=1: IF/ID holds all fields.
  - id_stall=0 and no instruction delivered this cycle: insert a bubble, IR=NOP_INST, valid=0; PC and NPC hold.
- Redirect (ex_take_branch=1) has top priority over stall, response and state:
  - pc <= {ex_target_pc[31:2],2'b00}.
  - IF/ID is flushed to a bubble even if id_stall=1.
  - The hold buffer is discarded.
  - In WAIT without a same-cycle response: set drop=1 and stay in WAIT.
  - In WAIT with a same-cycle response: discard the response and go to FETCH.
  - In FETCH or HOLD: go to FETCH, so the next req uses the target.
  - A redirect in the same cycle as a FETCH req still issues that req; drop is set so its response is discarded.
- Arithmetic: PC arithmetic is modulo 2^32; pc+4 at 32'hFFFF_FFFC wraps to 0.
- Throughput: with 1-cycle memory latency, one instruction is delivered every 2 cycles; the request is never pipelined.
- Outstanding requests: never more than one. proc2Imem_req is never asserted in WAIT or HOLD.

Decomposition:
- Shared package holds: the fetch_state_t enum {FETCH, WAIT, HOLD}, the NOP_INST constant, and a PC_WIDTH=32 constant, alongside the existing sys_defs macros.
- No sub-module: the FSM, PC register, hold buffer and IF/ID register fit in one module. The IF/ID register could optionally be split out as if_id_reg, but this is not required.

Test Plan:
- Reset then free run, 1-cycle memory returning addr^32'hA5A5_0000, no stall -> req at 0x0,0x4,0x8 every 2 cycles; IF/ID delivers PC 0x0/0x4/0x8 with valid=1; bubbles (valid=0, IR=0x13) between deliveries.
- id_stall=1 for 5 cycles while the response for 0x4 arrives -> FSM enters HOLD; IF/ID keeps PC 0x0; no req issued; on release IF/ID shows PC 0x4 next cycle, then req to 0x8.
- 4-cycle memory latency with ex_take_branch=1, target 0x100, in the 2nd WAIT cycle -> the late response for 0x8 is discarded; next req addr=0x100; first valid IF/ID PC=0x100, NPC=0x104.
- Redirect in the same cycle as the response and id_stall=1 -> IF/ID flushed (valid=0); response dropped; next req addr equals the target.
- ex_target_pc=0x203 -> req addr=0x200; pc=0xFFFF_FFFC delivered -> next req addr=0x0.
- rst asserted in WAIT, then a stale Imem2proc_valid arrives -> outputs stay at reset values; req to RESET_PC.
